// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM encoding for the word-parallel Trivium engine.
// Tap constants use the cipher's 1-based numbering (s1..s288); subtract 1 for vector indices.
package trivium_pkg;

  localparam int STATE_BITS    = 288;
  localparam int KEY_BITS      = 80;
  localparam int IV_BITS       = 80;
  localparam int WARMUP_ROUNDS = 1152;

  localparam int TAP_T1_A    = 66;
  localparam int TAP_T1_B    = 93;
  localparam int TAP_T1_AND0 = 91;
  localparam int TAP_T1_AND1 = 92;
  localparam int TAP_T1_C    = 171;
  localparam int TAP_T2_A    = 162;
  localparam int TAP_T2_B    = 177;
  localparam int TAP_T2_AND0 = 175;
  localparam int TAP_T2_AND1 = 176;
  localparam int TAP_T2_C    = 264;
  localparam int TAP_T3_A    = 243;
  localparam int TAP_T3_B    = 288;
  localparam int TAP_T3_AND0 = 286;
  localparam int TAP_T3_AND1 = 287;
  localparam int TAP_T3_C    = 69;

  // First bit of the second and third shift registers (first register starts at s1).
  localparam int REG_B_FIRST = 94;
  localparam int REG_C_FIRST = 178;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  function automatic bit legal_w(input int w);
    return (w >= 1) && (w <= 64) && ((WARMUP_ROUNDS % w) == 0);
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: 288-bit state in, advanced state and keystream bit out.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_BITS-1:0] s_cur,
  output logic [STATE_BITS-1:0] s_nxt,
  output logic                  z
);

  logic t1, t2, t3;
  logic t1_fb, t2_fb, t3_fb;

  always_comb begin
    t1 = s_cur[TAP_T1_A-1] ^ s_cur[TAP_T1_B-1];
    t2 = s_cur[TAP_T2_A-1] ^ s_cur[TAP_T2_B-1];
    t3 = s_cur[TAP_T3_A-1] ^ s_cur[TAP_T3_B-1];
    z  = t1 ^ t2 ^ t3;

    t1_fb = t1 ^ (s_cur[TAP_T1_AND0-1] & s_cur[TAP_T1_AND1-1]) ^ s_cur[TAP_T1_C-1];
    t2_fb = t2 ^ (s_cur[TAP_T2_AND0-1] & s_cur[TAP_T2_AND1-1]) ^ s_cur[TAP_T2_C-1];
    t3_fb = t3 ^ (s_cur[TAP_T3_AND0-1] & s_cur[TAP_T3_AND1-1]) ^ s_cur[TAP_T3_C-1];

    // Whole-vector shift up, then the three register heads take the feedback bits.
    s_nxt                = {s_cur[STATE_BITS-2:0], 1'b0};
    s_nxt[0]             = t3_fb;
    s_nxt[REG_B_FIRST-1] = t1_fb;
    s_nxt[REG_C_FIRST-1] = t2_fb;
  end

endmodule

// File: rtl/trivium_stream.sv
// Word-parallel Trivium keystream engine: W rounds per clock, internal key/IV load and
// warm-up sequencing, and a valid/ready output stream with optional din XOR.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W      = 8,
  parameter int XOR_EN = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key,
  input  logic [IV_BITS-1:0]  iv,
  input  logic                init,
  output logic                busy,
  output logic                ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        dout,
  output state_e              fsm_state
);

  localparam int WARM_CYC = WARMUP_ROUNDS / W;
  localparam int CNT_W    = $clog2(WARM_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_CYC - 1);

  if (!legal_w(W)) begin : g_bad_w
    $error("trivium_stream: W=%0d must be in 1..64 and divide 1152", W);
  end

  state_e                state, state_nxt;
  logic [STATE_BITS-1:0] st;
  logic [STATE_BITS-1:0] st_adv;
  logic [CNT_W-1:0]      cnt;
  logic [W-1:0]          z_word;
  logic [W-1:0]          word_nxt;
  logic                  stall_free;
  logic                  fire;

  function automatic logic [STATE_BITS-1:0] load_state(input logic [KEY_BITS-1:0] k,
                                                       input logic [IV_BITS-1:0]  v);
    logic [STATE_BITS-1:0] s;
    s                            = '0;
    s[KEY_BITS-1:0]              = k;
    s[REG_B_FIRST-1 +: IV_BITS]  = v;
    s[STATE_BITS-1 -: 3]         = 3'b111;
    return s;
  endfunction

  // Round k of the cycle feeds round k+1; z of round k lands in bit k.
  for (genvar k = 0; k < W; k++) begin : g_round
    logic [STATE_BITS-1:0] s_in;
    logic [STATE_BITS-1:0] s_out;
    if (k == 0) begin : g_first
      assign s_in = st;
    end else begin : g_next
      assign s_in = g_round[k-1].s_out;
    end
    trivium_round u_round (
      .s_cur (s_in),
      .s_nxt (s_out),
      .z     (z_word[k])
    );
  end

  assign st_adv    = g_round[W-1].s_out;
  assign word_nxt  = (XOR_EN != 0) ? (din ^ z_word) : z_word;
  assign fsm_state = state;

  // Handshake: a word moves on any edge where out_valid & out_ready; dout is frozen
  // while out_valid & !out_ready. The output register refills ("fire") only when it is
  // empty or being drained, and in XOR mode only together with an accepted din word.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    ready      = 1'b0;
    in_ready   = 1'b0;
    fire       = 1'b0;
    stall_free = !out_valid || out_ready;
    case (state)
      IDLE: ;
      WARMUP: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (XOR_EN != 0) begin
          in_ready = stall_free;
          fire     = in_valid && stall_free;
        end else begin
          fire = stall_free;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (init) state_nxt = WARMUP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      state <= state_nxt;
      if (init) begin
        st        <= load_state(key, iv);
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          WARMUP: begin
            st  <= st_adv;
            cnt <= cnt + 1'b1;
          end
          RUN: begin
            if (fire) begin
              st        <= st_adv;
              dout      <= word_nxt;
              out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
              out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: W=1 and W=8 keystream instances plus a W=16 XOR encrypt/decrypt
// pair, checked against an independent bit-serial Trivium model through expected queues.
module tb_trivium_stream;
  import trivium_pkg::*;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit main_done = 1'b0;

  // ---------------- instance A: W=1 keystream ----------------
  logic        rst_a, init_a, out_ready_a, in_valid_a;
  logic [79:0] key_a, iv_a;
  logic [0:0]  din_a, dout_a;
  logic        busy_a, ready_a, in_ready_a, out_valid_a;
  state_e      st_a;

  trivium_stream #(.W(1), .XOR_EN(0)) u_a (
    .clk(clk), .rst(rst_a), .key(key_a), .iv(iv_a), .init(init_a),
    .busy(busy_a), .ready(ready_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .din(din_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .dout(dout_a),
    .fsm_state(st_a)
  );

  // ---------------- instance B: W=8 keystream ----------------
  logic        rst_b, init_b, out_ready_b, in_valid_b;
  logic [79:0] key_b, iv_b;
  logic [7:0]  din_b, dout_b;
  logic        busy_b, ready_b, in_ready_b, out_valid_b;
  state_e      st_b;

  trivium_stream #(.W(8), .XOR_EN(0)) u_b (
    .clk(clk), .rst(rst_b), .key(key_b), .iv(iv_b), .init(init_b),
    .busy(busy_b), .ready(ready_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .din(din_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .dout(dout_b),
    .fsm_state(st_b)
  );

  // ---------------- instances C (encrypt) and D (decrypt): W=16 XOR ----------------
  logic        rst_x, init_x, in_valid_c, out_ready_d;
  logic [79:0] key_x, iv_x;
  logic [15:0] din_c, dout_c, dout_d;
  logic        busy_c, ready_c, in_ready_c, out_valid_c;
  logic        busy_d, ready_d, in_ready_d, out_valid_d;
  state_e      st_c, st_d;

  trivium_stream #(.W(16), .XOR_EN(1)) u_c (
    .clk(clk), .rst(rst_x), .key(key_x), .iv(iv_x), .init(init_x),
    .busy(busy_c), .ready(ready_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .din(din_c), .out_valid(out_valid_c), .out_ready(in_ready_d), .dout(dout_c),
    .fsm_state(st_c)
  );

  trivium_stream #(.W(16), .XOR_EN(1)) u_d (
    .clk(clk), .rst(rst_x), .key(key_x), .iv(iv_x), .init(init_x),
    .busy(busy_d), .ready(ready_d), .in_valid(out_valid_c), .in_ready(in_ready_d),
    .din(dout_c), .out_valid(out_valid_d), .out_ready(out_ready_d), .dout(dout_d),
    .fsm_state(st_d)
  );

  // ---------------- scoreboard ----------------
  logic [0:0]  exp_q_a[$];
  logic [7:0]  exp_q_b[$];
  logic [15:0] exp_q_c[$];
  logic [15:0] exp_q_d[$];
  bit          gold [0:4095];
  logic [15:0] din_tab [12] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h8001, 16'h5A5A,
                                16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h7FFE, 16'hC3C3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial reference, written directly in s1..s288 numbering.
  task automatic golden(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit s [1:288];
    bit t1, t2, t3;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (r >= 1152) gold[r - 1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
    end
  endtask

  function automatic logic [63:0] gold_word(input int idx, input int w);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r[b] = gold[idx * w + b];
    return r;
  endfunction

  // Monitor: a transfer is seen at the negedge before the edge that completes it.
  logic       b_hold = 1'b0;
  logic [7:0] b_prev = '0;
  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) begin
      if (exp_q_a.size() == 0) check("a_extra_word", 64'(out_valid_a), 64'd0);
      else check("a_dout", 64'(dout_a), 64'(exp_q_a.pop_front()));
    end
    if (b_hold && out_valid_b) check("b_dout_hold", 64'(dout_b), 64'(b_prev));
    b_hold = out_valid_b && !out_ready_b;
    b_prev = dout_b;
    if (out_valid_b && out_ready_b) begin
      if (exp_q_b.size() == 0) check("b_extra_word", 64'(out_valid_b), 64'd0);
      else check("b_dout", 64'(dout_b), 64'(exp_q_b.pop_front()));
    end
    if (out_valid_c && in_ready_d) begin
      if (exp_q_c.size() == 0) check("c_extra_word", 64'(out_valid_c), 64'd0);
      else check("c_cipher", 64'(dout_c), 64'(exp_q_c.pop_front()));
    end
    if (out_valid_d && out_ready_d) begin
      if (exp_q_d.size() == 0) check("d_extra_word", 64'(out_valid_d), 64'd0);
      else check("d_plain", 64'(dout_d), 64'(exp_q_d.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_init_b();
    init_b = 1'b1;
    @(posedge clk); #1;
    init_b = 1'b0;
  endtask

  task automatic run_warmup_b(input string tag);
    int busy_cnt, k;
    busy_cnt = busy_b ? 1 : 0;
    k = 0;
    while (!out_valid_b && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (busy_b) busy_cnt++;
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd144);
    check({tag, "_first_valid"}, 64'(k), 64'd145);
  endtask

  task automatic drain_b(input string tag, input bit toggle);
    int t;
    t = 0;
    while (exp_q_b.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      if (toggle) out_ready_b = ~out_ready_b;
      t++;
    end
    out_ready_b = 1'b0;
    check({tag, "_drained"}, 64'(exp_q_b.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int busy_cnt, k, t, viol;
    logic acc;
    logic [63:0] w;

    rst_a = 1; rst_b = 1; rst_x = 1;
    init_a = 0; init_b = 0; init_x = 0;
    out_ready_a = 0; out_ready_b = 0; out_ready_d = 0;
    in_valid_a = 0; in_valid_b = 0; in_valid_c = 0;
    din_a = '0; din_b = '0; din_c = '0;
    key_a = '0; iv_a = '0; key_b = '0; iv_b = '0; key_x = '0; iv_x = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 0; rst_b = 0; rst_x = 0;

    // Reset state
    check("rst_a_state", 64'(st_a), 64'(IDLE));
    check("rst_a_busy", 64'(busy_a), 64'd0);
    check("rst_a_ready", 64'(ready_a), 64'd0);
    check("rst_a_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_a_dout", 64'(dout_a), 64'd0);
    check("rst_b_state", 64'(st_b), 64'(IDLE));
    check("rst_b_dout", 64'(dout_b), 64'd0);
    check("rst_b_out_valid", 64'(out_valid_b), 64'd0);
    check("rst_c_state", 64'(st_c), 64'(IDLE));
    check("rst_c_in_ready", 64'(in_ready_c), 64'd0);
    check("rst_c_dout", 64'(dout_c), 64'd0);
    check("rst_d_in_ready", 64'(in_ready_d), 64'd0);

    // No activity for 2000 cycles without init
    viol = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (busy_a || ready_a || out_valid_a || busy_b || ready_b || out_valid_b ||
          busy_c || ready_c || out_valid_c || busy_d || ready_d || out_valid_d ||
          st_a != IDLE || st_c != IDLE) viol++;
    end
    check("idle_2000_cycles", 64'(viol), 64'd0);

    // A: W=1, zero key/iv, latency and first 64 bits
    golden(80'h0, 80'h0, 64);
    for (int i = 0; i < 64; i++) exp_q_a.push_back(gold[i]);
    init_a = 1;
    @(posedge clk); #1;
    init_a = 0;
    out_ready_a = 1;
    busy_cnt = busy_a ? 1 : 0;
    k = 0;
    while (!out_valid_a && k < 1300) begin
      @(posedge clk); #1;
      k++;
      if (busy_a) busy_cnt++;
    end
    check("a_busy_cycles", 64'(busy_cnt), 64'd1152);
    check("a_first_valid", 64'(k), 64'd1153);
    check("a_ready_run", 64'(ready_a), 64'd1);
    t = 0;
    while (exp_q_a.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    out_ready_a = 0;
    check("a_drained", 64'(exp_q_a.size()), 64'd0);

    // A: reset in the middle of warm-up
    init_a = 1;
    @(posedge clk); #1;
    init_a = 0;
    repeat (100) @(posedge clk);
    #1;
    check("a_busy_mid_warmup", 64'(busy_a), 64'd1);
    rst_a = 1;
    @(posedge clk); #1;
    rst_a = 0;
    check("a_rst_mid_state", 64'(st_a), 64'(IDLE));
    check("a_rst_mid_busy", 64'(busy_a), 64'd0);
    check("a_rst_mid_dout", 64'(dout_a), 64'd0);
    viol = 0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (busy_a || ready_a || out_valid_a) viol++;
    end
    check("a_rst_mid_quiet", 64'(viol), 64'd0);

    // B1: W=8 unstalled, 16 words
    key_b = 80'h0123456789ABCDEF0123;
    iv_b  = 80'hFEDCBA98765432100123;
    golden(key_b, iv_b, 256);
    for (int i = 0; i < 16; i++) begin w = gold_word(i, 8); exp_q_b.push_back(w[7:0]); end
    pulse_init_b();
    out_ready_b = 1;
    run_warmup_b("b1");
    drain_b("b1", 1'b0);

    // B2: restart while a word is pending, stall 5 cycles, then toggle out_ready
    for (int i = 0; i < 16; i++) begin w = gold_word(i, 8); exp_q_b.push_back(w[7:0]); end
    check("b2_pending_before", 64'(out_valid_b), 64'd1);
    pulse_init_b();
    check("b2_valid_drop", 64'(out_valid_b), 64'd0);
    run_warmup_b("b2");
    repeat (5) @(posedge clk);
    #1;
    out_ready_b = 1;
    drain_b("b2", 1'b1);

    // B3: 10 words, then re-init mid-RUN with a different iv
    for (int i = 0; i < 10; i++) begin w = gold_word(i, 8); exp_q_b.push_back(w[7:0]); end
    pulse_init_b();
    out_ready_b = 1;
    run_warmup_b("b3");
    drain_b("b3", 1'b0);
    iv_b = 80'h13579BDF02468ACE55AA;
    golden(key_b, iv_b, 128);
    for (int i = 0; i < 16; i++) begin w = gold_word(i, 8); exp_q_b.push_back(w[7:0]); end
    pulse_init_b();
    check("b4_valid_drop", 64'(out_valid_b), 64'd0);
    out_ready_b = 1;
    run_warmup_b("b4");
    drain_b("b4", 1'b0);

    // C/D: XOR mode encrypt then decrypt, W=16
    key_x = 80'h9A3C55F00E71B2D46C18;
    iv_x  = 80'h00001111222233334444;
    golden(key_x, iv_x, 12 * 16);
    for (int i = 0; i < 12; i++) begin
      w = gold_word(i, 16);
      exp_q_c.push_back(din_tab[i] ^ w[15:0]);
      exp_q_d.push_back(din_tab[i]);
    end
    out_ready_d = 1;
    init_x = 1;
    @(posedge clk); #1;
    init_x = 0;
    in_valid_c = 1;
    din_c = din_tab[0];
    viol = 0;
    t = 0;
    while (!ready_c && t < 200) begin
      if (in_ready_c) viol++;
      @(posedge clk); #1;
      t++;
    end
    check("x_in_ready_warmup", 64'(viol), 64'd0);
    check("x_warmup_cycles", 64'(t), 64'd72);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        in_valid_c = 0;
        repeat (3) @(posedge clk);
        #1;
      end
      in_valid_c = 1;
      din_c = din_tab[i];
      out_ready_d = (i % 4 != 3);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = in_ready_c;
        @(posedge clk); #1;
        out_ready_d = 1;
        t++;
      end
      check("x_accept", 64'(acc), 64'd1);
    end
    in_valid_c = 0;
    out_ready_d = 1;
    t = 0;
    while ((exp_q_c.size() != 0 || exp_q_d.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("c_drained", 64'(exp_q_c.size()), 64'd0);
    check("d_drained", 64'(exp_q_d.size()), 64'd0);

    repeat (5) @(posedge clk);
    main_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    check("watchdog_done", 64'(main_done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trivium_stream.md
Name: trivium_stream

Overview:
- Parametrised word-parallel Trivium keystream engine, successor to the bit-serial trivium core.
- Generates W keystream bits per clock and sequences key/IV load plus the 1152-round warm-up internally through an FSM.
- Provides a valid/ready output stream with backpressure.
- Optional XOR mode consumes a plaintext/ciphertext stream and emits the encrypted or decrypted words, so the block drops directly into a cipher datapath.

Parameters:
- W, 8: keystream bits per cycle. Legal values are 1..64 and must divide 1152; elaboration-time check.
- XOR_EN, 0: 0 = keystream-only source; 1 = output is din XOR keystream, gated by the input handshake.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- key  input  80  cipher key, bits [80:1], sampled on the init cycle.
- iv  input  80  initial value, bits [80:1], sampled on the init cycle.
- init  input  1  one-cycle pulse: load key/iv and start warm-up.
- busy  output  1  high while in WARMUP.
- ready  output  1  high in RUN; keystream available.
- in_valid  input  1  din valid (ignored when XOR_EN=0).
- in_ready  output  1  din accepted this cycle when in_valid & in_ready.
- din  input  W  data word to XOR (ignored when XOR_EN=0).
- out_valid  output  1  dout holds a valid word.
- out_ready  input  1  consumer accepts dout.
- dout  output  W  keystream word (XOR_EN=0) or din^keystream (XOR_EN=1). Bit 0 is the earliest-generated bit.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, 288-bit state=0, round counter=0, busy=0, ready=0, out_valid=0, dout=0, in_ready=0. Reset wins over init on the same edge.
- State load on init: s1..s80 = key[1..80]; s94..s173 = iv[1..80]; s286..s288 = 1; all other bits 0.
- One round:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69.
  - Shift each register up by one; s1=t3, s94=t1, s178=t2.
  - W rounds are chained combinationally per clock; z of round k goes to bit k.
- FSM:
  - IDLE: waits for init, then loads state and goes to WARMUP with counter=0.
  - WARMUP: advances W rounds per cycle and discards z. After exactly 1152/W cycles it enters RUN on the following edge. busy=1 throughout WARMUP.
  - RUN: ready=1. The state advances W rounds only on a "fire" cycle; otherwise it holds.
- Fire condition:
  - XOR_EN=0: fire = !out_valid | out_ready.
  - XOR_EN=1: fire = in_valid & in_ready, where in_ready = RUN & (!out_valid | out_ready).
- On fire, dout <= z_word (XOR_EN=0) or din ^ z_word (XOR_EN=1), and out_valid <= 1.
- If out_valid & out_ready & !fire, then out_valid <= 0.
- dout is held stable while out_valid & !out_ready. No word is dropped or duplicated.
- Latency: init at edge N gives the first out_valid at edge N + 1152/W + 1 (XOR_EN=0, out_ready=1). Throughput is one word per clock when unstalled.
- init during WARMUP or RUN: reload key/iv, restart warm-up, clear out_valid. The pending word is discarded.
- init while in IDLE is the normal start. in_valid before RUN is ignored and in_ready stays 0.
- Round counter width is clog2(1152/W+1) and never wraps; it is cleared on every init.

Decomposition:
- Package trivium_pkg holds:
  - STATE_BITS=288, KEY_BITS=80, IV_BITS=80, WARMUP_ROUNDS=1152.
  - Tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69).
  - FSM enum {IDLE, WARMUP, RUN}.
  - Function legal_w(W).
- Sub-module trivium_round: purely combinational, 288-bit state in, 288-bit next state out plus z. trivium_stream instantiates W of them in a generate chain.

Test Plan:
- rst=1 for 2 cycles, then 0 -> all outputs 0, FSM IDLE, no out_valid for 2000 cycles without init.
- W=1, key=0, iv=0, init pulse, out_ready=1 -> busy high exactly 1152 cycles, first out_valid 1153 cycles after init. First 64 bits match the bench's bit-serial golden model and the existing trivium core's sequence.
- W=8, key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100123 -> busy for 144 cycles. The 16 words of dout equal golden bits 0..127 packed LSB-first.
- W=8, XOR_EN=0, out_ready held 0 for 5 cycles then toggled every other cycle -> dout stable while stalled; word sequence identical to the unstalled run.
- XOR_EN=1, W=16: the din sequence is fed, then the output is fed back through a second instance with the same key/iv. The result equals the original din. With in_valid=0 for 3 cycles, no state advance occurs.
- init reasserted mid-RUN after 10 words, with different iv -> out_valid drops next cycle, busy for 1152/W cycles, and the new sequence matches the golden model for the new iv. rst asserted mid-WARMUP returns to IDLE.
